// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers one A and one B operand matrix from a byte stream, then drives the
// left (a) and top (b) edges of an N x N PE array with diagonal skew. A clear pulse goes out
// before streaming, and a done pulse once the far-corner PE has accumulated its last product.
// Optional build macro FEEDER_BCOL_EN: B bytes arrive column-major (host sends B^T rows);
// without it B arrives row-major. A is always row-major. Streaming order is the same in both.
module systolic_feeder #(
  parameter int unsigned N  = 2,
  parameter int unsigned DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic            clear,
  output logic [N*DW-1:0] a_lanes,
  output logic [N*DW-1:0] b_lanes,
  output logic            busy,
  output logic            done
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  // Step counter also serves as the drain counter; it must reach 2N-2.
  localparam int unsigned SW = $clog2(2 * N);

  localparam logic [CW-1:0] IdxLast   = CW'(N - 1);
  localparam logic [SW-1:0] StepLast  = SW'(2 * N - 2);
  localparam logic [SW-1:0] DrainLast = SW'(N - 1);

  typedef enum logic [2:0] {
    StLoad,
    StClr,
    StStream,
    StDrain,
    StDone
  } state_e;

  state_e        state_q;
  logic [CW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic          sel_b_q;
  logic [SW-1:0] cnt_q;

  logic [DW-1:0] a_buf [N][N];
  logic [DW-1:0] b_buf [N][N];

  logic            accept;
  logic            last_byte;
  logic [SW-1:0]   next_step;
  logic [N*DW-1:0] a_next;
  logic [N*DW-1:0] b_next;

  assign accept    = in_valid && in_ready;
  assign last_byte = sel_b_q && (row_q == IdxLast) && (col_q == IdxLast);

  // Step whose lane values are registered on the coming edge (CLR preloads step 0).
  assign next_step = (state_q == StClr) ? '0 : cnt_q + 1'b1;

  // Operand buffer write; contents need no reset since every entry is rewritten per matrix.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (!sel_b_q) begin
        a_buf[row_q][col_q] <= in_data;
      end else begin
`ifdef FEEDER_BCOL_EN
        // Column-major arrival: the running row/col counters address B transposed.
        b_buf[col_q][row_q] <= in_data;
`else
        b_buf[row_q][col_q] <= in_data;
`endif
      end
    end
  end

  // Skewed lane values for next_step: a lane i carries A[i][j] and b lane j carries B[i][j]
  // exactly when step == i + j, which gives each PE its matching operand pair.
  always_comb begin
    a_next = '0;
    b_next = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (int'(next_step) == i + j) begin
          a_next[i*DW +: DW] = a_buf[i][j];
          b_next[j*DW +: DW] = b_buf[i][j];
        end
      end
    end
  end

  // Sequencer with all outputs registered; reset aborts any matrix in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StLoad;
      row_q    <= '0;
      col_q    <= '0;
      sel_b_q  <= 1'b0;
      cnt_q    <= '0;
      in_ready <= 1'b0;
      clear    <= 1'b0;
      a_lanes  <= '0;
      b_lanes  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      clear <= 1'b0;
      done  <= 1'b0;
      unique case (state_q)
        StLoad: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (col_q == IdxLast) begin
              col_q <= '0;
              if (row_q == IdxLast) begin
                row_q   <= '0;
                sel_b_q <= ~sel_b_q;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
            if (last_byte) begin
              state_q  <= StClr;
              in_ready <= 1'b0;
              clear    <= 1'b1;
              busy     <= 1'b1;
            end
          end
        end
        StClr: begin
          state_q <= StStream;
          cnt_q   <= '0;
          a_lanes <= a_next;
          b_lanes <= b_next;
        end
        StStream: begin
          if (cnt_q == StepLast) begin
            state_q <= StDrain;
            cnt_q   <= '0;
            a_lanes <= '0;
            b_lanes <= '0;
          end else begin
            cnt_q   <= next_step;
            a_lanes <= a_next;
            b_lanes <= b_next;
          end
        end
        StDrain: begin
          // N idle cycles let the last operands reach PE(N-1,N-1) and accumulate.
          if (cnt_q == DrainLast) begin
            state_q <= StDone;
            cnt_q   <= '0;
            done    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          state_q  <= StLoad;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
        default: begin
          state_q <= StLoad;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: stimulus pushes expected per-cycle edge frames and the
// expected PE products; a negedge monitor pops and compares whenever a matrix window is active.
module tb_systolic_feeder;

  localparam int unsigned N   = 2;
  localparam int unsigned DW  = 8;
  localparam int          NN  = N * N;
  localparam int          Win = 3 * N + 1;

  typedef logic [DW-1:0] mat_t [N][N];
  typedef struct packed {
    logic            clr;
    logic [N*DW-1:0] a;
    logic [N*DW-1:0] b;
    logic            dn;
  } frame_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic            in_ready;
  logic            clear;
  logic            busy;
  logic            done;
  logic [N*DW-1:0] a_lanes;
  logic [N*DW-1:0] b_lanes;

  int     n_checks = 0;
  int     n_errors = 0;
  frame_t exp_q[$];
  int     exp_c_q[$];
  frame_t mf;
  int     win = 0;

  logic [DW-1:0] pa [N][N];
  logic [DW-1:0] pb [N][N];
  int            pc [N][N];

  systolic_feeder #(.N(N), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .clear    (clear),
    .a_lanes  (a_lanes),
    .b_lanes  (b_lanes),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Behavioural 2D PE grid: a flows right, b flows down, c accumulates a*b.
  function automatic logic [DW-1:0] a_src(input int i, input int j);
    if (j == 0) return a_lanes[i*DW +: DW];
    return pa[i][j-1];
  endfunction

  function automatic logic [DW-1:0] b_src(input int i, input int j);
    if (i == 0) return b_lanes[j*DW +: DW];
    return pb[i-1][j];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          pa[i][j] <= '0;
          pb[i][j] <= '0;
          pc[i][j] <= 0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          pa[i][j] <= a_src(i, j);
          pb[i][j] <= b_src(i, j);
          if (clear) pc[i][j] <= 0;
          else pc[i][j] <= pc[i][j] + int'(a_src(i, j)) * int'(b_src(i, j));
        end
      end
    end
  end

  // Monitor: a clear opens a window of 3N+1 frames that are compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      win = 0;
    end else begin
      if (win == 0 && clear) win = Win;
      if (win > 0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_frame: got clear=%0b a=%0h b=%0h, want no activity",
                   clear, a_lanes, b_lanes);
        end else begin
          mf = exp_q.pop_front();
          chk("clear", clear, mf.clr);
          chk("a_lanes", a_lanes, mf.a);
          chk("b_lanes", b_lanes, mf.b);
          chk("done", done, mf.dn);
          chk("busy_active", busy, 1);
          chk("in_ready_active", in_ready, 0);
        end
        win--;
      end else begin
        chk("idle_lanes", {a_lanes, b_lanes}, '0);
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
      end
      if (done) begin
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            if (exp_c_q.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL pe_c: got %0d, want nothing queued", pc[i][j]);
            end else begin
              chk($sformatf("pe_c%0d%0d", i, j), 64'(pc[i][j]), 64'(exp_c_q.pop_front()));
            end
          end
        end
      end
    end
  end

  task automatic build_mats(input logic [DW-1:0] bq[$], output mat_t a, output mat_t b);
    for (int n = 0; n < NN; n++) a[n/N][n%N] = bq[n];
    for (int m = 0; m < NN; m++) begin
`ifdef FEEDER_BCOL_EN
      b[m%N][m/N] = bq[NN+m];
`else
      b[m/N][m%N] = bq[NN+m];
`endif
    end
  endtask

  // Reference model: skewed edge schedule and the matrix product from plain arithmetic.
  task automatic push_model(input mat_t a, input mat_t b);
    frame_t f;
    int     s;
    f = '0;
    f.clr = 1'b1;
    exp_q.push_back(f);
    for (int k = 0; k < 2 * N - 1; k++) begin
      f = '0;
      for (int i = 0; i < N; i++) begin
        if (k - i >= 0 && k - i < N) begin
          f.a[i*DW +: DW] = a[i][k-i];
          f.b[i*DW +: DW] = b[k-i][i];
        end
      end
      exp_q.push_back(f);
    end
    for (int d = 0; d < N; d++) begin
      f = '0;
      exp_q.push_back(f);
    end
    f = '0;
    f.dn = 1'b1;
    exp_q.push_back(f);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int m = 0; m < N; m++) s += int'(a[i][m]) * int'(b[m][j]);
        exp_c_q.push_back(s);
      end
    end
  endtask

  // Fixed expectations for the 2x2 example (A=[1 2;3 4], B=[5 6;7 8]).
  task automatic push_directed();
    frame_t f;
    f = '0; f.clr = 1'b1;                               exp_q.push_back(f);
    f = '0; f.a = {8'd0, 8'd1}; f.b = {8'd0, 8'd5};     exp_q.push_back(f);
    f = '0; f.a = {8'd3, 8'd2}; f.b = {8'd6, 8'd7};     exp_q.push_back(f);
    f = '0; f.a = {8'd4, 8'd0}; f.b = {8'd8, 8'd0};     exp_q.push_back(f);
    f = '0;                                             exp_q.push_back(f);
    f = '0;                                             exp_q.push_back(f);
    f = '0; f.dn = 1'b1;                                exp_q.push_back(f);
    exp_c_q.push_back(19);
    exp_c_q.push_back(22);
    exp_c_q.push_back(43);
    exp_c_q.push_back(50);
  endtask

  // gap_mode: 0 none, 1 one idle cycle after each byte, 2 random 0..2 idle cycles.
  task automatic send_bytes(input logic [DW-1:0] bq[$], input int gap_mode, input bit junk);
    int t;
    int g;
    for (int n = 0; n < bq.size(); n++) begin
      t = 0;
      in_valid = 1'b1;
      in_data  = bq[n];
      while (!in_ready) begin
        @(posedge clk); #1;
        t++;
        if (t > 50) begin
          bound_fail("load_ready");
          in_valid = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
      if (n != bq.size() - 1) begin
        g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
        for (int c = 0; c < g; c++) begin
          in_valid = 1'b0;
          in_data  = DW'($urandom);
          @(posedge clk); #1;
        end
      end
    end
    if (junk) begin
      in_valid = 1'b1;
      in_data  = 8'hFF;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!in_ready) begin
      @(posedge clk); #1;
      t++;
      if (t > 100) begin
        bound_fail("wait_ready");
        return;
      end
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_q.size() != 0 || exp_c_q.size() != 0) begin
      @(posedge clk); #1;
      t++;
      if (t > 200) begin
        bound_fail("wait_idle");
        exp_q.delete();
        exp_c_q.delete();
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] dq[$];
    logic [DW-1:0] rq[$];
    mat_t          ma;
    mat_t          mb;
    bit            junk;

`ifdef FEEDER_BCOL_EN
    dq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd7, 8'd6, 8'd8};
`else
    dq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
`endif

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_clear", clear, 0);
    chk("rst_lanes", {a_lanes, b_lanes}, '0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);

    // Directed example, contiguous valid
    push_directed();
    send_bytes(dq, 0, 1'b0);
    wait_idle();

    // Same data with one idle cycle between bytes
    push_directed();
    send_bytes(dq, 1, 1'b0);
    wait_idle();

    // 0xFF held valid through the busy phase, then an immediate back-to-back load
    push_directed();
    send_bytes(dq, 0, 1'b1);
    wait_ready();
    push_directed();
    send_bytes(dq, 0, 1'b0);
    wait_idle();

    // Asynchronous reset in the middle of streaming
    push_directed();
    send_bytes(dq, 0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 0);
    chk("abort_clear", clear, 0);
    chk("abort_a_lanes", a_lanes, '0);
    chk("abort_b_lanes", b_lanes, '0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    exp_q.delete();
    exp_c_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready_again", in_ready, 1);

    // Recovery after abort
    push_directed();
    send_bytes(dq, 0, 1'b0);
    wait_idle();

    // Randomized matrices against the reference model
    for (int r = 0; r < 8; r++) begin
      rq.delete();
      for (int n = 0; n < 2 * NN; n++) rq.push_back(DW'($urandom));
      build_mats(rq, ma, mb);
      push_model(ma, mb);
      junk = 1'($urandom_range(0, 1));
      send_bytes(rq, 2, junk);
      if (junk) wait_ready();
      else wait_idle();
    end
    wait_idle();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
Upstream operand feeder for the N x N PE systolic array. It accepts A and B operand bytes over a valid/ready stream and buffers them in internal registers. It then drives the array's left edge (a lanes, one per row) and top edge (b lanes, one per column) with the diagonal skew the PEs require. It issues the PE clear pulse before each matrix and signals done once the last product has settled in PE(N-1,N-1).

Parameters:
N, 2, array dimension; lane count on each edge.
DW, 8, operand width in bits; matches the PE a_in/b_in width.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset).
in_valid  input  1  operand byte valid.
in_ready  output  1  feeder accepts a byte this cycle.
in_data  input  DW  operand byte.
clear  output  1  one-cycle accumulator clear to all PEs.
a_lanes  output  N*DW  lane i in bits [i*DW +: DW] goes to row i, PE column 0 a_in.
b_lanes  output  N*DW  lane j in bits [j*DW +: DW] goes to column j, PE row 0 b_in.
busy  output  1  high in every state except LOAD.
done  output  1  one-cycle pulse; array results are valid.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=LOAD, all counters 0.
  - in_ready=0 while rst=0, then 1 from the first cycle after release.
  - clear=0, a_lanes=0, b_lanes=0, busy=0, done=0.
  - Buffer contents are don't-care.
  - Reset asserted mid-operation aborts immediately. No done pulse is produced.
- All outputs are registered.
- States: LOAD -> CLR -> STREAM -> DRAIN -> DONE -> LOAD.
- LOAD:
  - in_ready=1; a byte is accepted when in_valid && in_ready.
  - Byte index n runs 0..2*N*N-1.
  - n < N*N: A[n/N][n%N]. Otherwise B[(n-N*N)/N][(n-N*N)%N]. Both are row-major.
  - Accepting byte 2*N*N-1 moves the state to CLR on the same edge and drops in_ready.
- CLR:
  - Lasts 1 cycle: clear=1, lanes=0.
- STREAM:
  - Lasts 2N-1 cycles with step k=0..2N-2.
  - a lane i = A[i][k-i] if 0 <= k-i < N, else 0.
  - b lane j = B[k-j][j] if 0 <= k-j < N, else 0.
- DRAIN:
  - Lasts N cycles with lanes=0, covering propagation to the far corner plus the PE accumulate cycle.
- DONE:
  - Lasts 1 cycle: done=1, lanes=0. Then LOAD, with in_ready=1 on the following cycle.
- in_ready=0 in every state except LOAD. in_valid outside LOAD is ignored, and no data is lost in the buffer.
- Timeline from the edge that accepts the last byte:
  - cycle 1: clear.
  - cycles 2..2N: stream.
  - next N cycles: drain.
  - cycle 3N+1: done.
- Operands are passed through unmodified. The feeder performs no arithmetic. Signedness is the PE's concern.
- in_valid held high across the LOAD boundary: the first byte is accepted in the first cycle in_ready=1.

Optional Feature:
Macro: FEEDER_BCOL_EN.
- Defined: B bytes are loaded column-major, i.e. byte N*N+m = B[m%N][m/N]. This lets the host send B^T rows directly. The streaming order is unchanged.
- Undefined: B is loaded row-major as specified above.
- A is row-major in both builds.

Test Plan:
1. Reset, then release.
   - Required: in_ready=1, busy=0, lanes=0, done=0.
   - Assert rst=0 mid-STREAM. Required: all outputs go to 0 asynchronously before the next clock edge.
2. N=2, bytes 1,2,3,4,5,6,7,8 with in_valid held high.
   - Required: clear=1 one cycle after the last byte.
   - a_lanes{lane1,lane0} per cycle: {0,1}, {3,2}, {4,0}.
   - b_lanes{lane1,lane0} per cycle: {0,5}, {6,7}, {8,0}.
   - Then 2 zero cycles, then done=1.
3. Same data through a 2x2 PE grid.
   - Required: at done, c_out = 19, 22, 43, 50 for PE00, PE01, PE10, PE11.
4. Gaps in in_valid (one-idle-cycle pattern) during LOAD.
   - Required: identical lane sequence to test 2, with no skipped or duplicated bytes.
5. in_valid=1 with data 0xFF throughout STREAM, DRAIN and DONE.
   - Required: in_ready=0 and lanes unaffected.
   - A second back-to-back load is accepted immediately after DONE and reproduces the test 2 results.
6. Build with FEEDER_BCOL_EN and send bytes 1,2,3,4,5,7,6,8.
   - Required: lane sequence identical to test 2.
